// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor: counter encodings,
// the sequential-PC increment and the mispredict condition.
package branch_predictor_pkg;

    localparam int          CTR_MAX_W = 4;
    localparam logic [31:0] PC_INC    = 32'd4;

    // Encodings are right-aligned in CTR_MAX_W bits; callers cast to their CTR_W.
    function automatic logic [CTR_MAX_W-1:0] WEAK_TAKEN(input int unsigned ctr_w);
        return CTR_MAX_W'(1) << (ctr_w - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] WEAK_NOT_TAKEN(input int unsigned ctr_w);
        return WEAK_TAKEN(ctr_w) - CTR_MAX_W'(1);
    endfunction

    function automatic logic is_mispredict(input logic        taken,
                                           input logic        pred_taken,
                                           input logic [31:0] target,
                                           input logic [31:0] pred_target);
        return (taken != pred_taken) || (taken && pred_taken && (target != pred_target));
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: fetch lookup, MEM-stage
// resolution, flush request and statistics.
interface branch_predictor_if #(
    parameter int STAT_W = 16
);
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_target;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispredict_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter for one predictor entry; resets to
// weakly-not-taken and supports a direct load on allocation.
module sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CTR_W-1:0] load_value,
    output logic [CTR_W-1:0] count
);
    localparam logic [CTR_W-1:0] RESET_VALUE = CTR_W'(WEAK_NOT_TAKEN(CTR_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (inc && !(&count)) begin
            count <= count + CTR_W'(1);
        end else if (dec && (count != '0)) begin
            count <= count - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor with saturating direction counters,
// registered mispredict/redirect and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int TAG_W  = 8,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bus
);
    localparam int               IDX            = $clog2(DEPTH);
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(WEAK_TAKEN(CTR_W));

    logic                          valid_q  [DEPTH];
    logic [TAG_W-1:0]              tag_q    [DEPTH];
    logic [31:0]                   target_q [DEPTH];
    logic [DEPTH-1:0][CTR_W-1:0]   ctr_q;

    logic [IDX-1:0]    if_idx;
    logic [IDX-1:0]    upd_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [TAG_W-1:0]  upd_tag;
    logic              if_hit;
    logic              upd_hit;
    logic              pred_taken;
    logic              upd_mispredict;
    logic              mispredict_q;
    logic [31:0]       redirect_pc_q;
    logic [STAT_W-1:0] branch_count_q;
    logic [STAT_W-1:0] mispredict_count_q;
    logic              unused_bits;

    assign if_idx  = bus.if_pc[IDX+1:2];
    assign if_tag  = bus.if_pc[IDX+TAG_W+1:IDX+2];
    assign upd_idx = bus.upd_pc[IDX+1:2];
    assign upd_tag = bus.upd_pc[IDX+TAG_W+1:IDX+2];

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads the array as it stands; a same-cycle update is not bypassed.
    assign pred_taken      = reset && if_hit && ctr_q[if_idx][CTR_W-1];
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_taken ? target_q[if_idx] : bus.if_pc + PC_INC;

    assign upd_mispredict = is_mispredict(bus.upd_taken, bus.upd_pred_taken,
                                          bus.upd_target, bus.upd_pred_target);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic entry_sel;
        assign entry_sel = bus.upd_valid && (upd_idx == IDX'(i));

        sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .inc        (entry_sel && upd_hit && bus.upd_taken),
            .dec        (entry_sel && upd_hit && !bus.upd_taken),
            .load       (entry_sel && !upd_hit && bus.upd_taken),
            .load_value (CTR_WEAK_TAKEN),
            .count      (ctr_q[i])
        );
    end

    // A taken update either refreshes the target of a hit or allocates the slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (bus.upd_valid && bus.upd_taken) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bus.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            mispredict_q <= bus.upd_valid && upd_mispredict;
            if (bus.upd_valid) begin
                redirect_pc_q <= bus.upd_taken ? bus.upd_target : bus.upd_pc + PC_INC;
                if (!(&branch_count_q)) begin
                    branch_count_q <= branch_count_q + STAT_W'(1);
                end
                if (upd_mispredict && !(&mispredict_count_q)) begin
                    mispredict_count_q <= mispredict_count_q + STAT_W'(1);
                end
            end
        end
    end

    assign bus.mispredict       = mispredict_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

    assign unused_bits = ^{bus.if_pc, bus.upd_pc, ctr_q};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed updates/lookups push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_branch_predictor;

    localparam int K_PRED = 0;
    localparam int K_MISP = 1;
    localparam int K_STAT = 2;

    typedef struct {
        int          due;
        string       name;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   failures = 0;
    exp_t sb[$];

    branch_predictor_if #(.STAT_W(8)) bus ();

    branch_predictor #(
        .DEPTH  (64),
        .TAG_W  (8),
        .CTR_W  (2),
        .STAT_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic rst, input logic [31:0] pc,
                                  input logic uv, input logic [31:0] upc,
                                  input logic ut, input logic [31:0] utgt,
                                  input logic upt, input logic [31:0] uptgt);
        @(posedge clk);
        #1;
        reset               = rst;
        bus.if_pc           = pc;
        bus.upd_valid       = uv;
        bus.upd_pc          = upc;
        bus.upd_taken       = ut;
        bus.upd_target      = utgt;
        bus.upd_pred_taken  = upt;
        bus.upd_pred_target = uptgt;
    endtask

    task automatic idle(input logic rst, input logic [31:0] pc);
        apply_stimulus(rst, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_item(input int delay, input string name, input int kind,
                               input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.due  = cyc + delay;
        e.name = name;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [31:0] got_a;
        logic [31:0] got_b;
        case (e.kind)
            K_PRED: begin
                got_a = 32'(bus.pred_taken);
                got_b = bus.pred_target;
            end
            K_MISP: begin
                got_a = 32'(bus.mispredict);
                got_b = bus.redirect_pc;
            end
            default: begin
                got_a = 32'(bus.branch_count);
                got_b = 32'(bus.mispredict_count);
            end
        endcase
        tests++;
        if (got_a !== e.a || got_b !== e.b || e.due != cyc) begin
            failures++;
            $display("[TB] FAIL %s (cycle %0d, due %0d): got %h/%h, expected %h/%h",
                     e.name, cyc, e.due, got_a, got_b, e.a, e.b);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            check_output(sb.pop_front());
        end
        cyc++;
    end

    initial begin
        bus.if_pc           = 32'h40;
        bus.upd_valid       = 1'b0;
        bus.upd_pc          = 32'h0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = 32'h0;
        bus.upd_pred_taken  = 1'b0;
        bus.upd_pred_target = 32'h0;

        // Reset and empty-table lookup
        idle(1'b0, 32'h40);
        expect_item(0, "reset_pred", K_PRED, 0, 32'h44);
        idle(1'b1, 32'h40);
        expect_item(0, "reset_pred2", K_PRED, 0, 32'h44);
        expect_item(0, "reset_misp", K_MISP, 0, 32'h0);
        expect_item(0, "reset_stats", K_STAT, 0, 0);

        // First taken branch allocates the entry
        apply_stimulus(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        expect_item(0, "first_lookup", K_PRED, 0, 32'h44);
        expect_item(1, "alloc_misp", K_MISP, 1, 32'h100);
        expect_item(1, "alloc_stats", K_STAT, 1, 1);
        idle(1, 32'h40);
        expect_item(0, "alloc_pred", K_PRED, 1, 32'h100);
        expect_item(1, "misp_pulse_end", K_MISP, 0, 32'h100);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100);
            expect_item(1, "correct_taken", K_MISP, 0, 32'h100);
        end

        // Two not-taken resolutions walk the counter 11 -> 10 -> 01
        apply_stimulus(1, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        expect_item(0, "strong_taken_pred", K_PRED, 1, 32'h100);
        expect_item(1, "nt_misp1", K_MISP, 1, 32'h44);
        apply_stimulus(1, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
        expect_item(0, "weak_taken_pred", K_PRED, 1, 32'h100);
        expect_item(1, "nt_misp2", K_MISP, 1, 32'h44);
        idle(1, 32'h40);
        expect_item(0, "weak_nt_pred", K_PRED, 0, 32'h44);
        expect_item(0, "stats_after_nt", K_STAT, 7, 3);

        // Taken hit rewrites the target
        apply_stimulus(1, 32'h40, 1, 32'h40, 1, 32'h200, 0, 32'h44);
        expect_item(1, "retarget_misp", K_MISP, 1, 32'h200);
        idle(1, 32'h40);
        expect_item(0, "retarget_pred", K_PRED, 1, 32'h200);

        // Not-taken miss allocates nothing
        apply_stimulus(1, 32'h40, 1, 32'h80, 0, 32'h0, 0, 32'h84);
        expect_item(1, "miss_nt_misp", K_MISP, 0, 32'h84);
        idle(1, 32'h80);
        expect_item(0, "miss_nt_no_alloc", K_PRED, 0, 32'h84);
        expect_item(0, "stats_mid", K_STAT, 9, 4);

        // Both taken but wrong target
        apply_stimulus(1, 32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h200);
        expect_item(1, "target_misp", K_MISP, 1, 32'h300);

        // Aliasing PC replaces the entry; same-cycle lookup sees old contents
        apply_stimulus(1, 32'h40, 1, 32'h140, 1, 32'h400, 0, 32'h144);
        expect_item(0, "same_cycle_old", K_PRED, 1, 32'h300);
        expect_item(1, "alias_misp", K_MISP, 1, 32'h400);
        idle(1, 32'h40);
        expect_item(0, "alias_evicted", K_PRED, 0, 32'h44);
        expect_item(0, "stats_alias", K_STAT, 11, 6);
        idle(1, 32'h140);
        expect_item(0, "alias_pred", K_PRED, 1, 32'h400);

        apply_stimulus(1, 32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h400);
        expect_item(0, "same_cycle_old2", K_PRED, 1, 32'h400);
        expect_item(1, "same_idx_misp", K_MISP, 1, 32'h144);
        idle(1, 32'h140);
        expect_item(0, "same_cycle_new", K_PRED, 0, 32'h144);
        expect_item(0, "stats_pre_sat", K_STAT, 12, 7);

        // Drive both statistics counters past all-ones
        for (int i = 0; i < 250; i++) begin
            apply_stimulus(1, 32'h80, 1, 32'h80, 0, 32'h0, 1, 32'h300);
        end
        apply_stimulus(1, 32'h80, 1, 32'h140, 1, 32'h500, 0, 32'h144);
        expect_item(0, "stats_saturated", K_STAT, 255, 255);
        expect_item(0, "last_loop_misp", K_MISP, 1, 32'h84);
        expect_item(1, "stats_hold", K_STAT, 255, 255);

        // Reset during an update: prediction gated, update discarded
        apply_stimulus(0, 32'h140, 1, 32'h40, 1, 32'h600, 0, 32'h44);
        expect_item(0, "reset_pred_gate", K_PRED, 0, 32'h144);
        expect_item(1, "reset_misp_clear", K_MISP, 0, 32'h0);
        expect_item(1, "reset_stats_clear", K_STAT, 0, 0);
        idle(1, 32'h140);
        expect_item(0, "post_reset_140", K_PRED, 0, 32'h144);
        idle(1, 32'h40);
        expect_item(0, "post_reset_40", K_PRED, 0, 32'h44);
        expect_item(0, "post_reset_misp", K_MISP, 0, 32'h0);
        expect_item(0, "post_reset_stats", K_STAT, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
